// File: rtl/if_stage.sv
// if_stage: instruction fetch with IF/ID register and optional 2-bit BHT (enable with `define IF_BHT_EN)
module if_stage #(
  parameter logic [7:0] RESET_PC  = 8'h00,
  parameter int         BHT_IDX_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [7:0]  imem_addr,
  input  logic [18:0] imem_data,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        flush,
  input  logic [7:0]  redirect_pc,
  input  logic        upd_en,
  input  logic [7:0]  upd_pc,
  input  logic        upd_taken,
  output logic [18:0] instruction,
  output logic [7:0]  pc_out,
  output logic [1:0]  prediction,
  output logic        valid
);
  typedef enum logic [1:0] {BOOT, RUN, WAIT_MEM, HOLD} state_t;
  state_t      r_state, w_state_nxt;
  logic [7:0]  r_pc, w_pc_nxt;
  logic [18:0] r_instr;
  logic [7:0]  r_pc_out;
  logic [1:0]  r_pred, w_pred;
  logic        r_valid, w_active, w_fetch, w_miss;
  assign imem_addr   = r_pc;
  assign instruction = r_instr;
  assign pc_out      = r_pc_out;
  assign prediction  = r_pred;
  assign valid       = r_valid;
`ifdef IF_BHT_EN
  logic [1:0] r_bht [2**BHT_IDX_W];
  logic       w_unused_upd;
  assign w_unused_upd = ^upd_pc;
  assign w_pred = r_bht[r_pc[BHT_IDX_W-1:0]];
  // Predicted next PC: taken branches jump by the signed 8-bit offset, everything else steps by one
  always_comb begin
    w_pc_nxt = (imem_data[18:17] == 2'b11 && w_pred[1]) ? r_pc + imem_data[7:0] : r_pc + 8'd1;
  end
  // 2-bit saturating counters trained by resolved branches; fetch sees the pre-update value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2**BHT_IDX_W; i++) r_bht[i] <= 2'b01;
    end else if (upd_en) begin
      r_bht[upd_pc[BHT_IDX_W-1:0]] <= upd_taken
        ? (r_bht[upd_pc[BHT_IDX_W-1:0]] == 2'b11 ? 2'b11 : r_bht[upd_pc[BHT_IDX_W-1:0]] + 2'b01)
        : (r_bht[upd_pc[BHT_IDX_W-1:0]] == 2'b00 ? 2'b00 : r_bht[upd_pc[BHT_IDX_W-1:0]] - 2'b01);
    end
  end
`else
  logic w_unused_upd;
  assign w_unused_upd = ^{upd_en, upd_pc, upd_taken} ^ (BHT_IDX_W > 0);
  assign w_pred = 2'b01;
  // Without a predictor the fetch stream is strictly sequential
  always_comb begin
    w_pc_nxt = r_pc + 8'd1;
  end
`endif
  // Next state and fetch decisions; flush beats stall beats memory readiness
  always_comb begin
    w_active    = !flush && r_state != BOOT && !stall;
    w_fetch     = w_active && imem_ready;
    w_miss      = w_active && !imem_ready;
    w_state_nxt = flush ? RUN
                : (r_state == BOOT) ? RUN
                : stall ? ((r_state == RUN && r_valid) ? HOLD : r_state)
                : imem_ready ? RUN : WAIT_MEM;
  end
  // PC, IF/ID register and FSM state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= BOOT;
      r_pc     <= RESET_PC;
      r_instr  <= 19'h0;
      r_pc_out <= 8'h00;
      r_pred   <= 2'b00;
      r_valid  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (flush) begin
        r_valid <= 1'b0;
        r_pc    <= redirect_pc;
      end else if (w_fetch) begin
        r_instr  <= imem_data;
        r_pc_out <= r_pc;
        r_pred   <= w_pred;
        r_valid  <= 1'b1;
        r_pc     <= w_pc_nxt;
      end else if (w_miss) begin
        r_valid <= 1'b0;
      end
    end
  end
endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter: RESET_PC, default 8'h00, fetch address after reset.
REQ-002 Parameter: BHT_IDX_W, default 4, BHT index width; the BHT has 2^BHT_IDX_W entries.
REQ-003 Port: clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 Port: rst  in  1  reset, asynchronous, active-high.
REQ-005 Port: imem_addr  out  8  word address to instruction memory (combinational read).
REQ-006 Port: imem_data  in  19  instruction word at imem_addr.
REQ-007 Port: imem_ready  in  1  imem_data valid this cycle.
REQ-008 Port: stall  in  1  ID cannot accept; hold the IF/ID register.
REQ-009 Port: flush  in  1  mispredict/redirect from a later stage.
REQ-010 Port: redirect_pc  in  8  new fetch address when flush=1.
REQ-011 Port: upd_en, upd_pc[7:0], upd_taken  in  1/8/1  resolved-branch BHT update.
REQ-012 Port: instruction  out  19  IF/ID instruction to id_stage.
REQ-013 Port: pc_out  out  8  PC of the instruction held in IF/ID.
REQ-014 Port: prediction  out  2  BHT counter used for this instruction.
REQ-015 Port: valid  out  1  IF/ID holds a real instruction.

Function
REQ-016 FSM states: BOOT, RUN, WAIT_MEM, HOLD.
REQ-017 BOOT: entered on reset; exits to RUN after one cycle; no fetch.
REQ-018 RUN: imem_addr=pc. If imem_ready=1 and stall=0: latch instruction/pc_out/prediction, valid<=1, pc<=next_pc. If imem_ready=0: valid<=0, go to WAIT_MEM.
REQ-019 WAIT_MEM: hold pc with valid=0; return to RUN when imem_ready=1, latching that word the same cycle.
REQ-020 HOLD: entered when stall=1 with valid=1; IF/ID and pc frozen; exits to RUN in the cycle stall falls.
REQ-021 Branch class: instr[18:17]==2'b11; offset = instr[7:0] as signed.
REQ-022 next_pc = pc+offset (mod 256) if branch class and prediction[1]=1, else pc+1 (mod 256); 8'hFF+1 wraps to 8'h00.
REQ-023 prediction = BHT[pc[BHT_IDX_W-1:0]], read in the fetch cycle.
REQ-024 BHT update on upd_en: index upd_pc[BHT_IDX_W-1:0]; saturating increment if upd_taken, else saturating decrement; 2'b11 and 2'b00 saturate.
REQ-025 Priority: flush > stall > imem_ready. Flush: valid<=0, pc<=redirect_pc, state<=RUN, in any state including HOLD and WAIT_MEM.
REQ-026 A BHT update and a fetch at the same index in the same cycle: the fetch reads the pre-update value.
REQ-027 Latency: instruction appears on IF/ID exactly 1 cycle after imem_addr presents its PC with imem_ready=1.

Reset
REQ-028 On rst: pc=RESET_PC, state=BOOT, instruction=19'h0, pc_out=8'h00, prediction=2'b00, valid=0, all BHT entries=2'b01.
REQ-029 Reset asserted mid-operation aborts any stall, wait or flush; nothing is retained.

Configuration
REQ-030 Macro IF_BHT_EN defined: BHT present per REQ-023/024.
REQ-031 IF_BHT_EN undefined: no BHT storage; prediction=2'b01 constant while valid=1; next_pc=pc+1 always; upd_* ports ignored.

Verification
REQ-032 Reset release, imem_ready=1, no stall: imem_addr 00,01,02 on consecutive cycles after BOOT; valid=1 one cycle later with pc_out=00.
REQ-033 stall=1 for 3 cycles while valid=1: instruction/pc_out unchanged and imem_addr constant; resumes at next PC when stall falls.
REQ-034 flush=1 with redirect_pc=8'h40 while stall=1: next cycle valid=0, imem_addr=8'h40.
REQ-035 IF_BHT_EN: three upd_taken=1 updates at pc 8'h05 leave the entry at 2'b11; fetching a branch at 8'h05 with offset 8'hFE gives prediction=2'b11 and next imem_addr=8'h03.
REQ-036 imem_ready=0 for 2 cycles at pc 8'h10: valid=0 during the wait; word latched with pc_out=8'h10 when ready returns.
REQ-037 pc=8'hFF, non-branch instruction: next imem_addr=8'h00.
